cmos_capture: RTL and testbench

- Downstream of the `ccd` CMOS/I2C configuration block.
- Holds off until sensor configuration completes (`cmos_finish`), then discards SKIP_FRAMES unstable frames.
- Afterwards assembles the sensor's 8-bit DVP byte stream into 16-bit RGB565 pixels, with frame/line markers and geometry error checking.
- Output feeds the frame buffer writer.

---
 rtl/cmos_capture.sv | 166 ++++++++++++++++
 tb/tb_cmos_capture.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_capture.sv
// cmos_capture: holds the DVP byte stream off until the sensor configuration
// has finished and the unstable start-up frames have gone by, then pairs bytes
// into RGB565 pixels with frame/line markers and frame geometry checking.
module cmos_capture #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_finish,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        line_end,
  output logic        frame_end,
  output logic        frame_err,
  output logic        capturing
);

  typedef enum logic [1:0] {IDLE, SKIP, WAIT_VS, ACTIVE} state_t;

  // Wide enough to hold SKIP_FRAMES itself, and at least one bit when it is 0.
  localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES - 1);
  localparam logic [10:0] H_EXP = 11'(H_PIXELS);
  localparam logic [9:0]  V_EXP = 10'(V_LINES);

  state_t state, state_nxt;

  logic              vs_d, hr_d;
  logic [7:0]        data_d;
  logic [SKIP_W-1:0] skip_cnt;
  logic              byte_sel;
  logic [7:0]        hi_byte;
  logic [10:0]       pix_cnt;
  logic [9:0]        line_cnt;
  logic              first_pending;

  logic              vs_rise, hr_fall, abort, pair_en, emit;
  logic              line_fall, frame_tick, enter_active;
  logic [10:0]       pix_cnt_inc;
  logic [9:0]        line_cnt_inc;

  // Single register stage on the sensor pins; edges are found by comparing pin to register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d   <= 1'b0;
      hr_d   <= 1'b0;
      data_d <= 8'h00;
    end else begin
      vs_d   <= cmos_vsync;
      hr_d   <= cmos_href;
      data_d <= cmos_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a dropped cmos_finish pulls everything back to IDLE ahead of any other move.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmos_finish) state_nxt = (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
      SKIP:    if (enter_active) state_nxt = ACTIVE;
      WAIT_VS: if (enter_active) state_nxt = ACTIVE;
      ACTIVE:  state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Decode of the events the datapath acts on; href during vsync is ignored entirely.
  always_comb begin
    vs_rise      = cmos_vsync & ~vs_d;
    hr_fall      = ~cmos_href & hr_d;
    abort        = (state != IDLE) & ~cmos_finish;
    pair_en      = (state == ACTIVE) & ~abort & hr_d & ~vs_d;
    emit         = pair_en & byte_sel;
    line_fall    = (state == ACTIVE) & ~abort & hr_fall & ~vs_d;
    frame_tick   = (state == ACTIVE) & ~abort & vs_rise;
    enter_active = ~abort & vs_rise &
                   (((state == SKIP) & (skip_cnt == SKIP_LAST)) | (state == WAIT_VS));
    pix_cnt_inc  = pix_cnt + {10'd0, emit};
    line_cnt_inc = (line_fall && line_cnt != 10'h3FF) ? line_cnt + 10'd1 : line_cnt;
  end

  assign capturing = (state == ACTIVE);

  // Byte pairing, strobes and geometry counters; line handling comes before the frame
  // check so a line ending on the vsync edge still belongs to the frame it closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data      <= 16'h0000;
      pix_valid     <= 1'b0;
      frame_start   <= 1'b0;
      line_end      <= 1'b0;
      frame_end     <= 1'b0;
      frame_err     <= 1'b0;
      skip_cnt      <= '0;
      byte_sel      <= 1'b0;
      hi_byte       <= 8'h00;
      pix_cnt       <= 11'd0;
      line_cnt      <= 10'd0;
      first_pending <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
      if (abort || state == IDLE) begin
        skip_cnt      <= '0;
        byte_sel      <= 1'b0;
        pix_cnt       <= 11'd0;
        line_cnt      <= 10'd0;
        first_pending <= 1'b0;
      end else begin
        if (state == SKIP && vs_rise) skip_cnt <= skip_cnt + 1'b1;
        if (enter_active) begin
          line_cnt      <= 10'd0;
          pix_cnt       <= 11'd0;
          byte_sel      <= 1'b0;
          first_pending <= 1'b1;
        end
        if (pair_en) begin
          byte_sel <= ~byte_sel;
          if (!byte_sel) begin
            hi_byte <= data_d;
          end else begin
            pix_data  <= {hi_byte, data_d};
            pix_valid <= 1'b1;
            pix_cnt   <= pix_cnt_inc;
            if (first_pending) begin
              frame_start   <= 1'b1;
              first_pending <= 1'b0;
            end
          end
        end else begin
          byte_sel <= 1'b0;
        end
        if (line_fall) begin
          line_end <= 1'b1;
          line_cnt <= line_cnt_inc;
          pix_cnt  <= 11'd0;
          if (pix_cnt_inc != H_EXP) frame_err <= 1'b1;
        end
        if (frame_tick) begin
          frame_end <= 1'b1;
          if (line_cnt_inc != V_EXP) frame_err <= 1'b1;
          line_cnt      <= 10'd0;
          pix_cnt       <= 11'd0;
          byte_sel      <= 1'b0;
          first_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_capture.sv
// Testbench for cmos_capture: two instances (skip 2 frames / skip none) share one
// sensor stimulus; a frame-level model predicts pixels and markers per instance.
module tb_cmos_capture;

  localparam int H     = 4;
  localparam int V     = 3;
  localparam int BYTES = 2 * H;

  typedef struct {
    logic [15:0] data;
    logic        fs;
    int          cyc;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmos_finish = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_data = 8'h00;
  logic [15:0] pd_o [2];
  logic        pv_o [2];
  logic        fs_o [2];
  logic        le_o [2];
  logic        fe_o [2];
  logic        err_o [2];
  logic        cap_o [2];

  cmos_capture #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(2)) dut_skip (
    .clk(clk), .rst_n(rst_n), .cmos_finish(cmos_finish), .cmos_vsync(cmos_vsync),
    .cmos_href(cmos_href), .cmos_data(cmos_data), .pix_data(pd_o[0]), .pix_valid(pv_o[0]),
    .frame_start(fs_o[0]), .line_end(le_o[0]), .frame_end(fe_o[0]), .frame_err(err_o[0]),
    .capturing(cap_o[0])
  );

  cmos_capture #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(0)) dut_noskip (
    .clk(clk), .rst_n(rst_n), .cmos_finish(cmos_finish), .cmos_vsync(cmos_vsync),
    .cmos_href(cmos_href), .cmos_data(cmos_data), .pix_data(pd_o[1]), .pix_valid(pv_o[1]),
    .frame_start(fs_o[1]), .line_end(le_o[1]), .frame_end(fe_o[1]), .frame_err(err_o[1]),
    .capturing(cap_o[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_le [2];
  int   n_fe [2];
  int   n_fs [2];
  pix_t qa [$];
  pix_t qb [$];

  // Frame-level reference model: an instance captures once finish is up and it has seen
  // enough vsync pulses since then.
  logic fin_drv = 1'b0;
  bit   fin_m = 1'b0;
  int   from_vs [2] = '{2, 1};
  int   vs_cnt [2];
  bit   err_m [2];
  int   lines_m [2];
  bit   fs_pend [2];
  int   exp_le [2];
  int   exp_fe [2];
  int   exp_fs [2];

  function automatic bit cap(input int d);
    return fin_m && (vs_cnt[d] >= from_vs[d]);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] data);
    @(posedge clk);
    #1;
    cmos_finish = fin_drv;
    cmos_vsync  = vs;
    cmos_href   = hr;
    cmos_data   = data;
  endtask

  task automatic push_pair(input logic [7:0] hi, input logic [7:0] lo);
    pix_t e;
    for (int d = 0; d < 2; d++) begin
      if (cap(d)) begin
        e.data = {hi, lo};
        e.fs   = fs_pend[d];
        e.cyc  = cyc + 2;
        if (fs_pend[d]) exp_fs[d]++;
        fs_pend[d] = 1'b0;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
      end
    end
  endtask

  task automatic send_line(input int n, input int gap, input bit pat);
    logic [7:0] pat_b [4];
    logic [7:0] b, prev;
    pat_b = '{8'hAB, 8'hCD, 8'h12, 8'h34};
    prev = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = (pat && i < 4) ? pat_b[i] : 8'($urandom);
      applyStimulus(1'b0, 1'b1, b);
      if (i % 2 == 1) push_pair(prev, b);
      prev = b;
    end
    for (int d = 0; d < 2; d++) begin
      if (cap(d)) begin
        exp_le[d]++;
        lines_m[d]++;
        if (n != BYTES) err_m[d] = 1'b1;
      end
    end
    for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_vs();
    for (int d = 0; d < 2; d++) begin
      if (cap(d)) begin
        exp_fe[d]++;
        if (lines_m[d] != V) err_m[d] = 1'b1;
      end
      lines_m[d] = 0;
      if (fin_m) vs_cnt[d]++;
      if (cap(d)) fs_pend[d] = 1'b1;
    end
    applyStimulus(1'b1, 1'b0, 8'($urandom));
    applyStimulus(1'b1, 1'b1, 8'($urandom));
    applyStimulus(1'b1, 1'b1, 8'($urandom));
    applyStimulus(1'b1, 1'b0, 8'($urandom));
    applyStimulus(1'b1, 1'b0, 8'($urandom));
    applyStimulus(1'b0, 1'b0, 8'($urandom));
    applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input int nlines, input int odd_line, input bit tight, input bit pat);
    for (int l = 0; l < nlines; l++)
      send_line((l == odd_line) ? BYTES - 1 : BYTES,
                (tight && l == nlines - 1) ? 0 : int'($urandom_range(4, 1)), pat && l == 0);
    send_vs();
  endtask

  task automatic set_finish(input logic f);
    fin_drv = f;
    fin_m   = f;
    for (int d = 0; d < 2; d++) begin
      vs_cnt[d]  = 0;
      lines_m[d] = 0;
      fs_pend[d] = 1'b0;
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic checkpoint(input string tag);
    repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s dut%0d pixels outstanding", tag, d), (d == 0) ? qa.size() : qb.size(), 0);
      checkOutput($sformatf("%s dut%0d line_end count", tag, d), n_le[d], exp_le[d]);
      checkOutput($sformatf("%s dut%0d frame_end count", tag, d), n_fe[d], exp_fe[d]);
      checkOutput($sformatf("%s dut%0d frame_start count", tag, d), n_fs[d], exp_fs[d]);
      checkOutput($sformatf("%s dut%0d frame_err", tag, d), err_o[d], err_m[d]);
      checkOutput($sformatf("%s dut%0d capturing", tag, d), cap_o[d], cap(d));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s dut%0d pix_valid", tag, d), pv_o[d], 0);
      checkOutput($sformatf("%s dut%0d pix_data", tag, d), pd_o[d], 0);
      checkOutput($sformatf("%s dut%0d frame_start", tag, d), fs_o[d], 0);
      checkOutput($sformatf("%s dut%0d line_end", tag, d), le_o[d], 0);
      checkOutput($sformatf("%s dut%0d frame_end", tag, d), fe_o[d], 0);
      checkOutput($sformatf("%s dut%0d frame_err", tag, d), err_o[d], 0);
      checkOutput($sformatf("%s dut%0d capturing", tag, d), cap_o[d], 0);
    end
  endtask

  // Monitor: every presented pixel is matched against the oldest expected one.
  always @(negedge clk) begin
    pix_t e;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (pv_o[d] === 1'b1) begin
          if (((d == 0) ? qa.size() : qb.size()) == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected pixel dut%0d: got %h, expected none", d, pd_o[d]);
          end else begin
            if (d == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            checkOutput($sformatf("dut%0d pix_data", d), pd_o[d], e.data);
            checkOutput($sformatf("dut%0d frame_start with pixel", d), fs_o[d], e.fs);
            checkOutput($sformatf("dut%0d pixel cycle", d), cyc, e.cyc);
          end
        end else if (fs_o[d] === 1'b1) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL dut%0d frame_start without pix_valid: got 1, expected 0", d);
        end
        if (le_o[d] === 1'b1) n_le[d]++;
        if (fe_o[d] === 1'b1) n_fe[d]++;
        if (fs_o[d] === 1'b1) n_fs[d]++;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b0, b1, b2;
    #1 rst_n = 1'b0;
    #3 check_reset_outputs("power-on reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] frame before configuration is ignored");
    send_frame(V, -1, 1'b0, 1'b0);
    checkpoint("unconfigured");

    $display("[TB] configuration done, skip sequence then capture");
    set_finish(1'b1);
    send_frame(V, -1, 1'b0, 1'b0);
    send_frame(V, -1, 1'b0, 1'b0);
    send_frame(V, -1, 1'b0, 1'b0);
    send_frame(V, -1, 1'b1, 1'b0);
    checkpoint("skip then capture");

    $display("[TB] known byte pattern, last line ending on vsync edge");
    send_frame(V, -1, 1'b1, 1'b1);
    checkpoint("pattern");

    $display("[TB] short frame");
    send_frame(V - 1, -1, 1'b0, 1'b0);
    checkpoint("short frame");

    $display("[TB] reset in the middle of a line");
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    applyStimulus(1'b0, 1'b1, b0);
    applyStimulus(1'b0, 1'b1, b1);
    push_pair(b0, b1);
    applyStimulus(1'b0, 1'b1, b2);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid-line reset");
    qa.delete();
    qb.delete();
    for (int d = 0; d < 2; d++) begin
      vs_cnt[d] = 0; err_m[d] = 1'b0; lines_m[d] = 0; fs_pend[d] = 1'b0;
      exp_le[d] = 0; exp_fe[d] = 0; exp_fs[d] = 0;
      n_le[d] = 0; n_fe[d] = 0; n_fs[d] = 0;
    end
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] capture after reset, odd line then good frame");
    send_frame(V, -1, 1'b0, 1'b0);
    send_frame(V, -1, 1'b0, 1'b0);
    send_frame(V, -1, 1'b0, 1'b0);
    send_frame(V, 1, 1'b0, 1'b0);
    send_frame(V, -1, 1'b0, 1'b0);
    checkpoint("odd line");

    $display("[TB] configuration dropped and restored mid-frame");
    send_line(BYTES, 2, 1'b0);
    set_finish(1'b0);
    send_line(BYTES, 2, 1'b0);
    set_finish(1'b1);
    send_line(BYTES, 2, 1'b0);
    send_vs();
    send_frame(V, -1, 1'b0, 1'b0);
    send_frame(V, -1, 1'b0, 1'b0);
    checkpoint("finish toggle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
